// File: rtl/fifo_fwft.sv
// fifo_fwft: first-word-fall-through synchronous FIFO over a 1-cycle-latency BRAM,
// with a two-word prefetch (BRAM read register + output register), occupancy flags and sticky overflow.
module fifo_fwft #(
    parameter int DATA_W          = 32,
    parameter int LOG2_FIFO_DEPTH = 4,
    parameter int AF_THRESH       = (1 << LOG2_FIFO_DEPTH) - 2,
    parameter int AE_THRESH       = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       flush,
    input  logic                       clr_flags,
    output logic [LOG2_FIFO_DEPTH:0]   count,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow
);
    localparam int DEPTH = 1 << LOG2_FIFO_DEPTH;
    localparam int CW    = LOG2_FIFO_DEPTH + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CW-1:0]     wr_ptr, rd_ptr, count_next;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid, wr_acc, pop, out_load, stage_move, rd_en;

    assign in_ready   = count < CW'(DEPTH);
    assign wr_acc     = in_valid && in_ready && !flush;
    assign pop        = out_valid && out_ready && !flush;
    assign out_load   = !out_valid || pop;
    assign stage_move = rd_valid && out_load;
    // Read a new word whenever the read register is free or draining into the output register.
    assign rd_en      = !flush && (rd_ptr != wr_ptr) && (!rd_valid || stage_move);
    assign count_next = flush ? '0 : count + CW'(wr_acc) - CW'(pop);

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr[LOG2_FIFO_DEPTH-1:0]] <= in_data;
        if (rd_en) rd_data <= mem[rd_ptr[LOG2_FIFO_DEPTH-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rd_valid     <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            count        <= '0;
            almost_full  <= (AF_THRESH == 0);
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
        end else begin
            overflow     <= (in_valid && !in_ready) || (overflow && !clr_flags);
            count        <= count_next;
            almost_full  <= count_next >= CW'(AF_THRESH);
            almost_empty <= count_next <= CW'(AE_THRESH);
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                rd_valid  <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                if (wr_acc) wr_ptr <= wr_ptr + CW'(1);
                if (rd_en) rd_ptr <= rd_ptr + CW'(1);
                rd_valid <= rd_en || (rd_valid && !stage_move);
                if (out_load) out_valid <= rd_valid;
                if (stage_move) out_data <= rd_data;
            end
        end
    end
endmodule

// File: tb/tb_fifo_fwft.sv
// tb_fifo_fwft: directed scenario tests for fifo_fwft (DATA_W=8, depth 8, AF=6, AE=1).
module tb_fifo_fwft;
    logic       clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, flush = 0, clr_flags = 0;
    logic [7:0] in_data = 0;
    logic       in_ready, out_valid, almost_full, almost_empty, overflow;
    logic [7:0] out_data;
    logic [3:0] count;
    logic [16:0] st;
    int n_checks = 0, n_fail = 0;

    fifo_fwft #(.DATA_W(8), .LOG2_FIFO_DEPTH(3), .AF_THRESH(6), .AE_THRESH(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .flush(flush),
        .clr_flags(clr_flags), .count(count), .almost_full(almost_full),
        .almost_empty(almost_empty), .overflow(overflow)
    );

    always #5 clk = ~clk;
    assign st = {in_ready, out_valid, almost_full, almost_empty, overflow, count, out_data};

    task automatic step;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (2) step;
        n_checks++; if (st !== 17'h12000) begin n_fail++; $display("FAIL reset_state: got %h expected %h", st, 17'h12000); end
        rst_n = 1;
        step;
    endtask

    task automatic test_latency;
        in_valid = 1; in_data = 8'hA5;
        step;
        in_valid = 0;
        n_checks++; if ({out_valid, count} !== {1'b0, 4'd1}) begin n_fail++; $display("FAIL lat_edge0: got valid=%b count=%0d expected valid=0 count=1", out_valid, count); end
        step;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_edge1: got valid=%b expected 0", out_valid); end
        step;
        n_checks++; if ({out_valid, out_data, count, almost_empty, almost_full} !== {1'b1, 8'hA5, 4'd1, 1'b1, 1'b0})
            begin n_fail++; $display("FAIL lat_edge2: got v=%b d=%h c=%0d ae=%b af=%b expected v=1 d=a5 c=1 ae=1 af=0", out_valid, out_data, count, almost_empty, almost_full); end
    endtask

    task automatic test_fill;
        flush = 1;
        step;
        flush = 0;
        n_checks++; if ({count, out_valid} !== 5'd0) begin n_fail++; $display("FAIL fill_flush: got count=%0d valid=%b expected 0 0", count, out_valid); end
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1; in_data = 8'(i);
            step;
            n_checks++; if ({count, almost_empty, almost_full, in_ready} !== {4'(i), i <= 1, i >= 6, i < 8})
                begin n_fail++; $display("FAIL fill_%0d: got c=%0d ae=%b af=%b rdy=%b expected c=%0d ae=%b af=%b rdy=%b", i, count, almost_empty, almost_full, in_ready, i, i <= 1, i >= 6, i < 8); end
        end
        in_data = 8'h09;
        step;
        in_valid = 0;
        n_checks++; if ({count, overflow} !== {4'd8, 1'b1}) begin n_fail++; $display("FAIL fill_refused: got c=%0d ovf=%b expected c=8 ovf=1", count, overflow); end
        step;
        n_checks++; if ({overflow, out_valid, out_data} !== {1'b1, 1'b1, 8'h01}) begin n_fail++; $display("FAIL fill_sticky: got ovf=%b v=%b d=%h expected 1 1 01", overflow, out_valid, out_data); end
        clr_flags = 1;
        step;
        clr_flags = 0;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_clr: got ovf=%b expected 0", overflow); end
    endtask

    task automatic test_full_pop;
        int exp_v;
        in_valid = 1; in_data = 8'h09; out_ready = 1;
        step;
        n_checks++; if ({count, in_ready, out_data, overflow} !== {4'd7, 1'b1, 8'h02, 1'b1})
            begin n_fail++; $display("FAIL full_pop: got c=%0d rdy=%b d=%h ovf=%b expected c=7 rdy=1 d=02 ovf=1", count, in_ready, out_data, overflow); end
        step;
        n_checks++; if ({count, out_data} !== {4'd7, 8'h03}) begin n_fail++; $display("FAIL full_wr_pop: got c=%0d d=%h expected c=7 d=03", count, out_data); end
        in_valid = 0; out_ready = 0; clr_flags = 1;
        step;
        clr_flags = 0;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_clr: got ovf=%b expected 0", overflow); end
        exp_v = 3;
        out_ready = 1;
        for (int c = 0; c < 20 && exp_v < 10; c++) begin
            if (out_valid) begin
                n_checks++; if (out_data !== 8'(exp_v)) begin n_fail++; $display("FAIL drain: got %h expected %h", out_data, 8'(exp_v)); end
                exp_v++;
            end
            step;
        end
        out_ready = 0;
        n_checks++; if (exp_v !== 10) begin n_fail++; $display("FAIL drain_cnt: got %0d words expected 7", exp_v - 3); end
        n_checks++; if ({count, out_valid} !== 5'd0) begin n_fail++; $display("FAIL drain_empty: got c=%0d v=%b expected 0 0", count, out_valid); end
    endtask

    task automatic test_stream;
        int sent = 0, rcv = 0, cyc = 0;
        int wr_cyc [32];
        logic prev_stall = 0;
        logic [7:0] prev_data = 0;
        for (int c = 0; c < 400 && rcv < 32; c++) begin
            if (prev_stall) begin
                n_checks++; if ({out_valid, out_data} !== {1'b1, prev_data}) begin n_fail++; $display("FAIL stall_stable: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, prev_data); end
            end
            if (rcv < sent && wr_cyc[rcv] <= cyc - 2) begin
                n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bubble: word %0d got valid=%b expected 1", rcv, out_valid); end
            end
            out_ready = ($urandom_range(0, 4) < 3);
            in_valid = (sent < 32) && in_ready;
            in_data = 8'(sent);
            if (out_valid && out_ready) begin
                n_checks++; if (out_data !== 8'(rcv)) begin n_fail++; $display("FAIL stream_order: got %h expected %h", out_data, 8'(rcv)); end
                rcv++;
            end
            if (in_valid) begin wr_cyc[sent] = cyc + 1; sent++; end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            step;
            cyc++;
        end
        in_valid = 0; out_ready = 0;
        n_checks++; if (rcv !== 32) begin n_fail++; $display("FAIL stream_cnt: got %0d words expected 32", rcv); end
        n_checks++; if ({count, overflow} !== 5'd0) begin n_fail++; $display("FAIL stream_end: got c=%0d ovf=%b expected 0 0", count, overflow); end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1; in_data = 8'(8'h10 + i);
            step;
        end
        in_valid = 0; out_ready = 1;
        repeat (3) step;
        out_ready = 0;
        n_checks++; if ({count, overflow, out_data} !== {4'd5, 1'b1, 8'h13}) begin n_fail++; $display("FAIL flush_pre: got c=%0d ovf=%b d=%h expected 5 1 13", count, overflow, out_data); end
        flush = 1; in_valid = 1; in_data = 8'h77; out_ready = 1;
        step;
        flush = 0; in_valid = 0; out_ready = 0;
        n_checks++; if ({count, out_valid, in_ready, almost_empty, almost_full, overflow} !== {4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1})
            begin n_fail++; $display("FAIL flush_state: got c=%0d v=%b rdy=%b ae=%b af=%b ovf=%b expected 0 0 1 1 0 1", count, out_valid, in_ready, almost_empty, almost_full, overflow); end
        in_valid = 1; in_data = 8'h3C;
        step;
        in_valid = 0;
        n_checks++; if ({count, out_valid} !== {4'd1, 1'b0}) begin n_fail++; $display("FAIL flush_wr0: got c=%0d v=%b expected 1 0", count, out_valid); end
        step;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_wr1: got v=%b expected 0", out_valid); end
        step;
        n_checks++; if ({out_valid, out_data} !== {1'b1, 8'h3C}) begin n_fail++; $display("FAIL flush_wr2: got v=%b d=%h expected 1 3c", out_valid, out_data); end
        out_ready = 1;
        step;
        out_ready = 0; clr_flags = 1;
        n_checks++; if ({count, out_valid} !== 5'd0) begin n_fail++; $display("FAIL flush_leftover: got c=%0d v=%b expected 0 0", count, out_valid); end
        step;
        clr_flags = 0;
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_data = 8'(8'hC0 + i);
            step;
        end
        in_valid = 0;
        step;
        n_checks++; if ({out_valid, out_data, count} !== {1'b1, 8'hC0, 4'd4}) begin n_fail++; $display("FAIL arst_pre: got v=%b d=%h c=%0d expected 1 c0 4", out_valid, out_data, count); end
        in_valid = 1; in_data = 8'hC4; out_ready = 1;
        #2 rst_n = 0;
        #1;
        n_checks++; if (st !== 17'h12000) begin n_fail++; $display("FAIL arst_immediate: got %h expected %h", st, 17'h12000); end
        in_valid = 0; out_ready = 0;
        step;
        rst_n = 1; in_valid = 1; in_data = 8'h5A;
        step;
        in_valid = 0;
        n_checks++; if ({count, out_valid} !== {4'd1, 1'b0}) begin n_fail++; $display("FAIL arst_wr0: got c=%0d v=%b expected 1 0", count, out_valid); end
        step;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_wr1: got v=%b expected 0", out_valid); end
        step;
        n_checks++; if ({out_valid, out_data, count} !== {1'b1, 8'h5A, 4'd1}) begin n_fail++; $display("FAIL arst_wr2: got v=%b d=%h c=%0d expected 1 5a 1", out_valid, out_data, count); end
        out_ready = 1;
        step;
        out_ready = 0;
        n_checks++; if ({count, out_valid} !== 5'd0) begin n_fail++; $display("FAIL arst_drop: got c=%0d v=%b expected 0 0", count, out_valid); end
    endtask

    initial begin
        test_reset;
        test_latency;
        test_fill;
        test_full_pop;
        test_stream;
        test_flush;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
